// File: rtl/net_engine_sink_pkg.sv
// Shared types and constants for the net engine AXI4-Stream sink.
package net_engine_sink_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      IN_FRAME = 2'd1,
      FULL     = 2'd2
   } sink_state_t;

   localparam int SINK_SLOT_W = 3;
   localparam int SINK_SUM_W  = 32;

endpackage

// File: rtl/net_engine_sink_ram.sv
// Simple dual-port capture RAM: one write port, one registered read port.
module net_engine_sink_ram #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 64,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd_data_reg;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_data_reg <= '0;
      end else if (rd_en) begin
         rd_data_reg <= mem[rd_addr];
      end
   end

   assign rd_data = rd_data_reg;

endmodule

// File: rtl/net_engine_axis_sink.sv
// AXI4-Stream sink: circular capture buffer, beat/frame counters, patterned backpressure.
// Optional per-frame byte checksum built when NET_ENGINE_SINK_CHECKSUM_EN is defined.
module net_engine_axis_sink
   import net_engine_sink_pkg::*;
#(
   parameter int C_S00_AXIS_TDATA_WIDTH = 32,
   parameter int C_SINK_DEPTH           = 64
) (
   input  logic                                s00_axis_aclk,
   input  logic                                s00_axis_aresetn,
   output logic                                s00_axis_tready,
   input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
   input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
   input  logic                                s00_axis_tlast,
   input  logic                                s00_axis_tvalid,
   input  logic [7:0]                          bp_pattern,
   input  logic                                clear,
   input  logic                                rd_en,
   output logic [C_S00_AXIS_TDATA_WIDTH-1:0]   rd_data,
   output logic                                rd_valid,
   output logic [$clog2(C_SINK_DEPTH):0]       fill_level,
   output logic [31:0]                         beat_count,
   output logic [31:0]                         frame_count,
   output logic [31:0]                         frame_sum,
   output logic                                in_frame
);

   localparam int AW = $clog2(C_SINK_DEPTH);
   localparam int LW = AW + 1;
   localparam int NB = C_S00_AXIS_TDATA_WIDTH / 8;
   localparam logic [LW-1:0] LEVEL_MAX = LW'(C_SINK_DEPTH);

   sink_state_t            state_reg, state_next;
   logic                   frame_rec_reg, frame_rec_next;
   logic [SINK_SLOT_W-1:0] slot_reg;
   logic [AW-1:0]          wr_ptr_reg, rd_ptr_reg;
   logic [LW-1:0]          fill_reg, fill_next;
   logic [31:0]            beat_count_reg, frame_count_reg;
   logic                   rd_valid_reg;
   logic                   ready, accept, rd_fire;

   assign ready   = s00_axis_aresetn && !clear && (state_reg != FULL) &&
                    (fill_reg < LEVEL_MAX) && bp_pattern[slot_reg];
   assign accept  = s00_axis_tvalid && ready;
   assign rd_fire = rd_en && (fill_reg != '0) && !clear;

   always_comb begin
      fill_next = fill_reg;
      if (accept && !rd_fire) begin
         fill_next = fill_reg + LW'(1);
      end else if (!accept && rd_fire) begin
         fill_next = fill_reg - LW'(1);
      end
   end

   // frame_rec holds the partial-frame state to restore when FULL drains
   always_comb begin
      state_next     = state_reg;
      frame_rec_next = frame_rec_reg;
      case (state_reg)
         IDLE:     if (accept && !s00_axis_tlast) state_next = IN_FRAME;
         IN_FRAME: if (accept && s00_axis_tlast) state_next = IDLE;
         FULL:     if (rd_fire) state_next = frame_rec_reg ? IN_FRAME : IDLE;
         default:  state_next = IDLE;
      endcase
      if (fill_next == LEVEL_MAX && state_reg != FULL) begin
         frame_rec_next = (state_next == IN_FRAME);
         state_next     = FULL;
      end
   end

   always_ff @(posedge s00_axis_aclk) begin
      if (!s00_axis_aresetn || clear) begin
         state_reg       <= IDLE;
         frame_rec_reg   <= 1'b0;
         slot_reg        <= '0;
         wr_ptr_reg      <= '0;
         rd_ptr_reg      <= '0;
         fill_reg        <= '0;
         beat_count_reg  <= '0;
         frame_count_reg <= '0;
         rd_valid_reg    <= 1'b0;
      end else begin
         state_reg     <= state_next;
         frame_rec_reg <= frame_rec_next;
         slot_reg      <= slot_reg + SINK_SLOT_W'(1);
         fill_reg      <= fill_next;
         rd_valid_reg  <= rd_fire;
         if (accept) begin
            wr_ptr_reg     <= wr_ptr_reg + AW'(1);
            beat_count_reg <= beat_count_reg + 32'd1;
            if (s00_axis_tlast) begin
               frame_count_reg <= frame_count_reg + 32'd1;
            end
         end
         if (rd_fire) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
      end
   end

   net_engine_sink_ram #(
      .DATA_W (C_S00_AXIS_TDATA_WIDTH),
      .DEPTH  (C_SINK_DEPTH),
      .ADDR_W (AW)
   ) u_ram (
      .clk     (s00_axis_aclk),
      .rst_n   (s00_axis_aresetn),
      .wr_en   (accept),
      .wr_addr (wr_ptr_reg),
      .wr_data (s00_axis_tdata),
      .rd_en   (rd_fire),
      .rd_addr (rd_ptr_reg),
      .rd_data (rd_data)
   );

`ifdef NET_ENGINE_SINK_CHECKSUM_EN
   logic [SINK_SUM_W-1:0] lane_val [NB];
   logic [SINK_SUM_W-1:0] beat_sum;
   logic [SINK_SUM_W-1:0] run_sum_reg, frame_sum_reg;

   generate
      for (genvar gi = 0; gi < NB; gi++) begin : g_lane
         assign lane_val[gi] = s00_axis_tstrb[gi] ?
                               SINK_SUM_W'(s00_axis_tdata[gi*8 +: 8]) : '0;
      end
   endgenerate

   always_comb begin
      beat_sum = '0;
      for (int i = 0; i < NB; i++) begin
         beat_sum = beat_sum + lane_val[i];
      end
   end

   always_ff @(posedge s00_axis_aclk) begin
      if (!s00_axis_aresetn || clear) begin
         run_sum_reg   <= '0;
         frame_sum_reg <= '0;
      end else if (accept) begin
         if (s00_axis_tlast) begin
            frame_sum_reg <= run_sum_reg + beat_sum;
            run_sum_reg   <= '0;
         end else begin
            run_sum_reg <= run_sum_reg + beat_sum;
         end
      end
   end

   assign frame_sum = frame_sum_reg;
`else
   logic unused_strb;
   assign unused_strb = ^s00_axis_tstrb;
   assign frame_sum   = '0;
`endif

   assign s00_axis_tready = ready;
   assign rd_valid        = rd_valid_reg;
   assign fill_level      = fill_reg;
   assign beat_count      = beat_count_reg;
   assign frame_count     = frame_count_reg;
   assign in_frame        = (state_reg == IN_FRAME) || (state_reg == FULL && frame_rec_reg);

endmodule
